hc595_serial_driver: RTL

- Upstream controller for the 74HC595 shift/latch stage (`top`).
- Accepts a parallel word over a valid/ready handshake and serialises it onto A with SHIFTCLOCK.
- Pulses LATCHCLOCK to transfer the word to Qa..Qh, and drives OUTPUTENABLE.
- Runs on one system clock; every 595-side strobe is a registered, divided phase.

---
 rtl/hc595_pkg.sv | 23 ++
 rtl/hc595_phase_timer.sv | 32 +++
 rtl/hc595_serial_driver.sv | 135 +++++++++++++
 3 files changed

// File: rtl/hc595_pkg.sv
// Shared types and helpers for the 74HC595 serial driver.
// Optional feature macro: HC595_POWERUP_BLANK_EN (see hc595_serial_driver).
package hc595_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    localparam int DEFAULT_WIDTH   = 8;
    localparam int DEFAULT_CLK_DIV = 2;

    // Ceiling log2; clog2(n+1) gives the bits needed to hold the value n.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/hc595_phase_timer.sv
// Phase timer: counts CLK_DIV system clocks per 595 strobe phase and flags the
// last cycle of each phase. A start pulse restarts the count from zero.
module hc595_phase_timer
    import hc595_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic CLOCK,
    input  logic RESET,
    input  logic start,
    input  logic enable,
    output logic phase_done
);

    localparam int CW = clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            count <= '0;
        end else if (start || !enable || count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign phase_done = enable && !start && (count == LAST);

endmodule

// File: rtl/hc595_serial_driver.sv
// Upstream controller for a 74HC595 chain: serialises a word onto A/SHIFTCLOCK,
// then pulses LATCHCLOCK. Macro HC595_POWERUP_BLANK_EN holds OUTPUTENABLE high
// until the first completed latch.
module hc595_serial_driver
    import hc595_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int CLK_DIV   = DEFAULT_CLK_DIV,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] DATA,
    input  logic             VALID,
    output logic             READY,
    output logic             DONE,
    output logic             A,
    output logic             SHIFTCLOCK,
    output logic             LATCHCLOCK,
    output logic             OUTPUTENABLE,
    output state_t           STATE
);

    // Handshake: a word is taken on any CLOCK edge where VALID && READY; READY
    // is high only in IDLE, so VALID during a transfer is simply ignored.

    localparam int BW = clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_next;
    logic [BW-1:0]    bit_cnt;
    logic             accept;
    logic             phase_done;
    logic             first_bit;
    logic             next_bit;

    assign accept = (state == IDLE) && VALID && READY;
    assign STATE  = state;

    // The bit on A always sits at the outgoing end of shreg.
    always_comb begin
        shreg_next = shreg;
        first_bit  = 1'b0;
        next_bit   = 1'b0;
        if (MSB_FIRST != 0) begin
            first_bit  = DATA[WIDTH-1];
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
            next_bit   = shreg[WIDTH-2];
        end else begin
            first_bit  = DATA[0];
            shreg_next = {1'b0, shreg[WIDTH-1:1]};
            next_bit   = shreg[1];
        end
    end

    hc595_phase_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .CLOCK      (CLOCK),
        .RESET      (RESET),
        .start      (accept),
        .enable     (state != IDLE),
        .phase_done (phase_done)
    );

    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state      <= IDLE;
            READY      <= 1'b1;
            DONE       <= 1'b0;
            A          <= 1'b0;
            SHIFTCLOCK <= 1'b0;
            LATCHCLOCK <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shreg      <= DATA;
                        A          <= first_bit;
                        SHIFTCLOCK <= 1'b0;
                        READY      <= 1'b0;
                        bit_cnt    <= '0;
                        state      <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (phase_done) begin
                        SHIFTCLOCK <= 1'b1;
                        state      <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (phase_done) begin
                        SHIFTCLOCK <= 1'b0;
                        if (bit_cnt == LAST_BIT) begin
                            LATCHCLOCK <= 1'b1;
                            state      <= LATCH;
                        end else begin
                            shreg   <= shreg_next;
                            A       <= next_bit;
                            bit_cnt <= bit_cnt + 1'b1;
                            state   <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (phase_done) begin
                        LATCHCLOCK <= 1'b0;
                        DONE       <= 1'b1;
                        READY      <= 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef HC595_POWERUP_BLANK_EN
    // Keep the 595 outputs off until its storage register holds a real word.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            OUTPUTENABLE <= 1'b1;
        end else if (state == LATCH && phase_done) begin
            OUTPUTENABLE <= 1'b0;
        end
    end
`else
    assign OUTPUTENABLE = 1'b0;
`endif

endmodule
